prefetch_fetcher: RTL and testbench

Parametrised instruction fetcher with a prefetch buffer. It sits between the core's decode stage and program memory. It runs ahead of the consumer, issuing sequential program-memory reads into a DEPTH-entry instruction FIFO. A PC redirect (branch/jump) flushes the FIFO and drops any in-flight response. At most one memory request is outstanding at a time.

---
 rtl/gpu_pkg.sv | 12 +
 rtl/instr_fifo.sv | 71 +++++++
 rtl/prefetch_fetcher.sv | 122 ++++++++++++
 tb/tb_prefetch_fetcher.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types for the instruction-fetch front end.
// Holds the request FSM state encoding used by prefetch_fetcher. The same
// encoding is exported on its fetcher_state debug port.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    DISCARD = 2'd2
  } fetcher_state_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding prefetched {pc, instr} entries.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write din at the tail (ignored when full unless popping)
//   pop         remove the head (ignored when empty)
//   flush       empty the FIFO; takes priority over push and pop
//   full, empty, count  occupancy status
//   head        head entry, forced to zero while empty
module instr_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Zero the head while empty so the consumer-facing outputs read zero
  // after reset and flush instead of stale storage.
  assign head    = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));

endmodule

// File: rtl/prefetch_fetcher.sv
// Instruction fetcher with prefetch buffer.
// Issues sequential program-memory reads ahead of the decode stage into a
// DEPTH-entry FIFO. A redirect flushes the FIFO, reloads the fetch PC and
// drops any response still in flight. One request outstanding at most.
// Ports:
//   fetch_en                  allow new requests (an outstanding one completes)
//   redirect_valid/_pc        load a new fetch PC and flush
//   prog_mem_read_valid/_addr registered read request
//   prog_mem_read_ready/_data one-cycle response strobe with data
//   instr_valid/_ready/_data/_pc  consumer side, head of the FIFO
//   fetcher_state             request FSM state (IDLE/WAITING/DISCARD)
// Handshakes: the request is held (valid and addr stable) until the
// one-cycle ready strobe; the consumer pops the head on any cycle where
// instr_valid && instr_ready, except when a redirect flushes that cycle.
module prefetch_fetcher
  import gpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    INSTR_WIDTH = 16,
  parameter int                    DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   prog_mem_read_valid,
  output logic [ADDR_WIDTH-1:0]  prog_mem_read_addr,
  input  logic                   prog_mem_read_ready,
  input  logic [INSTR_WIDTH-1:0] prog_mem_read_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic [1:0]             fetcher_state
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = ADDR_WIDTH + INSTR_WIDTH;

  fetcher_state_t        state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EW-1:0]         fifo_head;
  logic                  can_issue;
  logic                  fifo_push;
  logic                  fifo_pop;

  // Issue only from IDLE, where no push is pending, so plain occupancy is
  // the space check; pops this cycle are deliberately not credited.
  assign can_issue = fetch_en && !redirect_valid && (fifo_count < CW'(DEPTH));
  assign fifo_push = (state == WAITING) && prog_mem_read_ready && !redirect_valid;
  assign fifo_pop  = instr_valid && instr_ready;

  instr_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .din   ({prog_mem_read_addr, prog_mem_read_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign instr_valid   = !fifo_empty;
  assign instr_pc      = fifo_head[EW-1:INSTR_WIDTH];
  assign instr_data    = fifo_head[INSTR_WIDTH-1:0];
  assign fetcher_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      fetch_pc            <= RESET_PC;
      prog_mem_read_valid <= 1'b0;
      prog_mem_read_addr  <= '0;
    end else begin
      if (redirect_valid) fetch_pc <= redirect_pc;
      case (state)
        IDLE: begin
          if (can_issue) begin
            prog_mem_read_valid <= 1'b1;
            prog_mem_read_addr  <= fetch_pc;
            fetch_pc            <= fetch_pc + 1'b1;
            state               <= WAITING;
          end
        end
        WAITING: begin
          // A response coinciding with a redirect is simply dropped.
          if (prog_mem_read_ready) begin
            prog_mem_read_valid <= 1'b0;
            state               <= IDLE;
          end else if (redirect_valid) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (prog_mem_read_ready) begin
            prog_mem_read_valid <= 1'b0;
            state               <= IDLE;
          end
        end
        default: begin
          prog_mem_read_valid <= 1'b0;
          state               <= IDLE;
        end
      endcase
    end
  end

  a_push_has_room: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_prefetch_fetcher.sv
module tb_prefetch_fetcher;

  localparam int AW = 8;
  localparam int IW = 16;
  localparam int MEM_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          prog_mem_read_valid;
  logic [AW-1:0] prog_mem_read_addr;
  logic          prog_mem_read_ready;
  logic [IW-1:0] prog_mem_read_data;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [IW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic [1:0]    fetcher_state;

  // memory: automatic latency model or manual strobe from the test
  logic          mem_auto = 1'b0;
  logic          auto_ready = 1'b0;
  logic [IW-1:0] auto_data = '0;
  logic          man_ready = 1'b0;
  logic [IW-1:0] man_data = '0;
  int            lat_cnt = 0;

  assign prog_mem_read_ready = mem_auto ? auto_ready : man_ready;
  assign prog_mem_read_data  = mem_auto ? auto_data  : man_data;

  logic [AW+IW-1:0] exp_q[$];
  logic [AW-1:0]    req_q[$];
  int checks = 0;
  int errors = 0;
  logic valid_d = 1'b0;

  prefetch_fetcher #(
    .ADDR_WIDTH  (AW),
    .INSTR_WIDTH (IW),
    .DEPTH       (4),
    .RESET_PC    (8'h10)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fetch_en            (fetch_en),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .prog_mem_read_valid (prog_mem_read_valid),
    .prog_mem_read_addr  (prog_mem_read_addr),
    .prog_mem_read_ready (prog_mem_read_ready),
    .prog_mem_read_data  (prog_mem_read_data),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .instr_data          (instr_data),
    .instr_pc            (instr_pc),
    .fetcher_state       (fetcher_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  always @(negedge clk) begin
    if (auto_ready) begin
      auto_ready = 1'b0;
      lat_cnt    = 0;
    end else if (mem_auto && prog_mem_read_valid) begin
      if (lat_cnt == MEM_LAT - 1) begin
        auto_ready = 1'b1;
        auto_data  = mem_data(prog_mem_read_addr);
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    #2;
    if (prog_mem_read_valid && !valid_d) begin
      if (req_q.size() == 0) begin
        check("unexpected_request", {24'h0, prog_mem_read_addr}, 32'hFFFF_FFFF);
      end else begin
        check("request_addr", {24'h0, prog_mem_read_addr}, {24'h0, req_q.pop_front()});
      end
    end
    valid_d = prog_mem_read_valid;
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_instr", {8'h0, instr_pc, instr_data}, 32'hFFFF_FFFF);
      end else begin
        check("instr_pc_data", {8'h0, instr_pc, instr_data}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic expect_seq(input logic [AW-1:0] start, input int n);
    logic [AW-1:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      req_q.push_back(a);
      exp_q.push_back({a, mem_data(a)});
      a = a + 1'b1;
    end
  endtask

  task automatic wait_req_empty(input string name, input int budget);
    int n;
    n = 0;
    while (req_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, req_q.size(), 0);
  endtask

  task automatic wait_exp_empty(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset values
    #12;
    check("rst_valid", prog_mem_read_valid, 0);
    check("rst_addr", prog_mem_read_addr, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_data", instr_data, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_state", fetcher_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // sequential fill from RESET_PC with no consumer
    @(negedge clk);
    mem_auto = 1'b1;
    req_q.push_back(8'h10); req_q.push_back(8'h11);
    req_q.push_back(8'h12); req_q.push_back(8'h13);
    for (int i = 0; i < 12; i++) exp_q.push_back({8'h10 + 8'(i), mem_data(8'h10 + 8'(i))});
    fetch_en = 1'b1;
    repeat (30) @(negedge clk);
    check("fill_req_done", req_q.size(), 0);
    check("fill_valid_low", prog_mem_read_valid, 0);
    check("fill_state_idle", fetcher_state, 0);
    check("fill_instr_valid", instr_valid, 1);
    check("fill_head_pc", instr_pc, 32'h10);

    // streaming drain through 0x1B
    for (int i = 4; i < 12; i++) req_q.push_back(8'h10 + 8'(i));
    instr_ready = 1'b1;
    wait_req_empty("drain_req_done", 200);
    fetch_en = 1'b0;
    wait_exp_empty("drain_instr_done", 50);
    instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("drain_empty", instr_valid, 0);
    check("drain_state_idle", fetcher_state, 0);

    // redirect while WAITING
    mem_auto = 1'b0;
    @(negedge clk);
    req_q.push_back(8'h1C);
    fetch_en = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 8'h80;
    req_q.push_back(8'h80);
    @(negedge clk);
    redirect_valid = 1'b0;
    check("redir_state_discard", fetcher_state, 2);
    check("redir_valid_held", prog_mem_read_valid, 1);
    check("redir_addr_held", prog_mem_read_addr, 32'h1C);
    man_ready = 1'b1;
    man_data = 16'hDEAD;
    @(negedge clk);
    man_ready = 1'b0;
    check("redir_back_idle", fetcher_state, 0);
    check("redir_valid_drop", prog_mem_read_valid, 0);
    @(negedge clk);
    fetch_en = 1'b0;
    check("redir_new_addr", prog_mem_read_addr, 32'h80);
    check("redir_stale_dropped", instr_valid, 0);
    @(negedge clk);
    man_ready = 1'b1;
    man_data = mem_data(8'h80);
    @(negedge clk);
    man_ready = 1'b0;
    @(negedge clk);
    check("redir_first_valid", instr_valid, 1);
    check("redir_first_pc", instr_pc, 32'h80);
    check("redir_first_data", instr_data, {16'h0, mem_data(8'h80)});

    // redirect coincident with ready and pop
    @(negedge clk);
    req_q.push_back(8'h81);
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 8'hFE;
    man_ready = 1'b1;
    man_data = 16'hBEEF;
    instr_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    man_ready = 1'b0;
    instr_ready = 1'b0;
    check("coinc_fifo_empty", instr_valid, 0);
    check("coinc_state_idle", fetcher_state, 0);
    check("coinc_valid_low", prog_mem_read_valid, 0);

    // wrap-around 0xFE..0x01
    mem_auto = 1'b1;
    expect_seq(8'hFE, 4);
    fetch_en = 1'b1;
    repeat (30) @(negedge clk);
    check("wrap_req_done", req_q.size(), 0);
    check("wrap_valid_low", prog_mem_read_valid, 0);
    check("wrap_head_pc", instr_pc, 32'hFE);
    fetch_en = 1'b0;
    instr_ready = 1'b1;
    wait_exp_empty("wrap_drain_done", 30);
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);

    // async reset while WAITING
    mem_auto = 1'b0;
    @(negedge clk);
    req_q.push_back(8'h02);
    fetch_en = 1'b1;
    @(negedge clk);
    check("ar_valid_before", prog_mem_read_valid, 1);
    check("ar_state_before", fetcher_state, 1);
    #3;
    rst_n = 1'b0;
    fetch_en = 1'b0;
    #1;
    check("ar_valid", prog_mem_read_valid, 0);
    check("ar_addr", prog_mem_read_addr, 0);
    check("ar_state", fetcher_state, 0);
    check("ar_instr_valid", instr_valid, 0);
    check("ar_instr_pc", instr_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    man_ready = 1'b1;
    man_data = 16'h1234;
    @(negedge clk);
    man_ready = 1'b0;
    @(negedge clk);
    check("ar_stray_no_push", instr_valid, 0);
    check("ar_stray_state", fetcher_state, 0);
    check("ar_stray_valid", prog_mem_read_valid, 0);
    repeat (3) @(negedge clk);
    check("final_req_q_empty", req_q.size(), 0);
    check("final_exp_q_empty", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
